// File: rtl/half_adder_pkg.sv
// Shared defaults and types for the registered half adder.
// Optional feature macro: HALF_ADDER_CNT_EN (carry-event counter).
package half_adder_pkg;

   localparam int WIDTH = 1;
   localparam int CNT_W = 16;

   typedef logic [WIDTH-1:0] ha_lane_t;
   typedef logic [CNT_W-1:0] ha_cnt_t;

   localparam ha_cnt_t HA_CNT_MAX = '1;

endpackage : half_adder_pkg

// File: rtl/intf.sv
// Operand/result bundle for half_adder. The rtl modport is the block side;
// the tb modport plus clocking block cb is the bench side.
interface intf #(
   parameter int WIDTH = half_adder_pkg::WIDTH
) (
   input logic clk
);
   import half_adder_pkg::*;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] c;

   clocking cb @(posedge clk);
      default input #2 output #2;
      output a, b;
      input  s, c;
   endclocking

   modport tb  (output a, b, input s, c, clocking cb);
   modport rtl (input a, b, output s, c);

endinterface : intf

// File: rtl/half_adder_lane.sv
// One registered half-adder lane: s = a ^ b, c = a & b, one cycle late,
// with an asynchronous active-low clear.
module half_adder_lane (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   logic s_d, s_q;
   logic c_d, c_q;

   // Combinational sum/carry of this lane's operand bits; X/Z flows through
   always_comb begin
      s_d = a ^ b;
      c_d = a & b;
   end

   // Result register, forced to zero the moment rst drops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         s_q <= s_d;
         c_q <= c_d;
      end
   end

   assign s = s_q;
   assign c = c_q;

endmodule : half_adder_lane

// File: rtl/half_adder.sv
// Registered multi-lane half adder. WIDTH independent lanes, no carry
// between lanes. With HALF_ADDER_CNT_EN defined, a saturating counter of
// cycles whose registered carry is non-zero is exposed on carry_cnt.
module half_adder #(
   parameter int WIDTH = half_adder_pkg::WIDTH,
   parameter int CNT_W = half_adder_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   intf.rtl                 ha_itf
`ifdef HALF_ADDER_CNT_EN
   ,
   output logic [CNT_W-1:0] carry_cnt
`endif
);
   import half_adder_pkg::*;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("half_adder: CNT_W must be at least 1");
   end

   logic [WIDTH-1:0] s_vec;
   logic [WIDTH-1:0] c_vec;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_lane u_lane (
         .clk (clk),
         .rst (rst),
         .a   (ha_itf.a[i]),
         .b   (ha_itf.b[i]),
         .s   (s_vec[i]),
         .c   (c_vec[i])
      );
   end

   assign ha_itf.s = s_vec;
   assign ha_itf.c = c_vec;

`ifdef HALF_ADDER_CNT_EN
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Count edges that see a registered carry on any lane; stick at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if ((|c_vec) && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register, cleared asynchronously with the lanes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign carry_cnt = cnt_q;
`endif

endmodule : half_adder

// File: tb/tb_half_adder.sv
module tb_half_adder;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   intf #(.WIDTH(1)) itf1 (.clk(clk));
   intf #(.WIDTH(4)) itf4 (.clk(clk));
   intf #(.WIDTH(1)) itf3 (.clk(clk));

`ifdef HALF_ADDER_CNT_EN
   logic [15:0] cnt1, cnt4;
   logic [2:0]  cnt3;
`endif

   half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .ha_itf(itf1.rtl)
`ifdef HALF_ADDER_CNT_EN
      , .carry_cnt(cnt1)
`endif
   );

   half_adder #(.WIDTH(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .ha_itf(itf4.rtl)
`ifdef HALF_ADDER_CNT_EN
      , .carry_cnt(cnt4)
`endif
   );

   half_adder #(.WIDTH(1), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .ha_itf(itf3.rtl)
`ifdef HALF_ADDER_CNT_EN
      , .carry_cnt(cnt3)
`endif
   );

   // scoreboards: {c,s} expected per DUT
   logic [1:0] q1[$];
   logic [7:0] q4[$];

   task automatic sample_point();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      itf1.a = 1'b1; itf1.b = 1'b1;
      itf4.a = 4'hF; itf4.b = 4'hF;
      itf3.a = 1'b1; itf3.b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample_point();
         checks++;
         if ({itf1.c, itf1.s} !== 2'b00 || {itf4.c, itf4.s} !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold cyc%0d: got c1s1=%b c4s4=%h expected 0", k, {itf1.c, itf1.s}, {itf4.c, itf4.s});
         end
`ifdef HALF_ADDER_CNT_EN
         checks++;
         if (cnt1 !== 16'd0 || cnt3 !== 3'd0) begin
            failures++;
            $display("FAIL reset_cnt cyc%0d: got cnt1=%0d cnt3=%0d expected 0", k, cnt1, cnt3);
         end
`endif
      end
      // first result after release comes from the first edge with rst=1
      @(negedge clk);
      rst = 1'b1;
      sample_point();
      checks++;
      if ({itf1.c, itf1.s} !== 2'b10) begin
         failures++;
         $display("FAIL reset_release: got %b expected 10", {itf1.c, itf1.s});
      end
   endtask

   task automatic test_exhaustive();
      logic [1:0] v, exp_cs;
      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         @(negedge clk);
         itf1.a = v[1];
         itf1.b = v[0];
         q1.push_back(2'({1'b0, v[1]} + {1'b0, v[0]}));
         sample_point();
         checks++;
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL exhaustive_%0d: scoreboard empty", i);
         end else begin
            exp_cs = q1.pop_front();
            if ({itf1.c, itf1.s} !== exp_cs) begin
               failures++;
               $display("FAIL exhaustive_%0d: got {c,s}=%b expected %b", i, {itf1.c, itf1.s}, exp_cs);
            end
         end
      end
   endtask

   // per-lane arithmetic model: {c[i],s[i]} = a[i] + b[i]
   function automatic logic [7:0] lane_model(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] se, ce;
      logic [1:0] sum;
      for (int i = 0; i < 4; i++) begin
         sum   = {1'b0, a[i]} + {1'b0, b[i]};
         se[i] = sum[0];
         ce[i] = sum[1];
      end
      return {ce, se};
   endfunction

   task automatic test_lanes();
      logic [7:0] exp_cs;
      @(negedge clk);
      itf4.a = 4'b1100;
      itf4.b = 4'b1010;
      q4.push_back(lane_model(4'b1100, 4'b1010));
      sample_point();
      exp_cs = q4.pop_front();
      checks++;
      if (itf4.s !== exp_cs[3:0]) begin
         failures++;
         $display("FAIL lanes_s: got %b expected %b", itf4.s, exp_cs[3:0]);
      end
      checks++;
      if (itf4.c !== exp_cs[7:4]) begin
         failures++;
         $display("FAIL lanes_c: got %b expected %b", itf4.c, exp_cs[7:4]);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ra, rb;
      logic [7:0] exp_cs;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         itf4.a = ra;
         itf4.b = rb;
         q4.push_back(lane_model(ra, rb));
         // mid-cycle change after the edge must not leak into the result
         sample_point();
         itf4.a = ~ra;
         checks++;
         if (q4.size() == 0) begin
            failures++;
            $display("FAIL b2b_%0d: scoreboard empty", k);
         end else begin
            exp_cs = q4.pop_front();
            if ({itf4.c, itf4.s} !== exp_cs) begin
               failures++;
               $display("FAIL b2b_%0d: got {c,s}=%h expected %h (a=%b b=%b)", k, {itf4.c, itf4.s}, exp_cs, ra, rb);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      itf1.a = 1'b1;
      itf1.b = 1'b1;
      sample_point();
      checks++;
      if (itf1.c !== 1'b1) begin
         failures++;
         $display("FAIL async_pre: got c=%b expected 1", itf1.c);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (itf1.c !== 1'b0 || itf1.s !== 1'b0) begin
         failures++;
         $display("FAIL async_clear: got c=%b s=%b expected 0 0 before next edge", itf1.c, itf1.s);
      end
`ifdef HALF_ADDER_CNT_EN
      checks++;
      if (cnt1 !== 16'd0) begin
         failures++;
         $display("FAIL async_cnt_clear: got %0d expected 0", cnt1);
      end
`endif
      sample_point();
      checks++;
      if (itf1.c !== 1'b0) begin
         failures++;
         $display("FAIL async_hold: got c=%b expected 0", itf1.c);
      end
      @(negedge clk);
      rst = 1'b1;
      sample_point();
      checks++;
      if (itf1.c !== 1'b1 || itf1.s !== 1'b0) begin
         failures++;
         $display("FAIL async_release: got c=%b s=%b expected 1 0", itf1.c, itf1.s);
      end
   endtask

   task automatic test_counter();
`ifdef HALF_ADDER_CNT_EN
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (cnt1 !== 16'd0 || cnt3 !== 3'd0) begin
         failures++;
         $display("FAIL cnt_reset: got cnt1=%0d cnt3=%0d expected 0", cnt1, cnt3);
      end
      @(negedge clk);
      rst = 1'b1;
      itf1.a = 1'b0; itf1.b = 1'b0;
      itf3.a = 1'b0; itf3.b = 1'b0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         itf1.a = (k < 5);
         itf1.b = (k < 5);
         itf3.a = (k < 10);
         itf3.b = (k < 10);
      end
      sample_point();
      sample_point();
      checks++;
      if (cnt1 !== 16'd5) begin
         failures++;
         $display("FAIL cnt_count: got %0d expected 5", cnt1);
      end
      checks++;
      if (cnt3 !== 3'd7) begin
         failures++;
         $display("FAIL cnt_saturate: got %0d expected 7", cnt3);
      end
`else
      // without the counter the exhaustive vectors must still hold
      test_exhaustive();
`endif
   endtask

   initial begin
      test_reset();
      test_exhaustive();
      test_lanes();
      test_back_to_back();
      test_async_reset();
      test_counter();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_half_adder

// File: doc/half_adder.md
# half_adder

Registered half adder: each clock adds 1-bit operands `a` and `b` per lane and presents sum `s` and carry `c` one cycle later. The operands and results travel over the shared `intf` interface. The block connects through the `rtl` modport, and benches connect through the `tb` modport and its clocking block. It is a leaf arithmetic block used as a building primitive and as an interface/clocking reference design.

## Interface
**Parameters**
- `WIDTH`, default 1: number of independent half-adder lanes.
- `CNT_W`, default 16: width of the carry-event counter.

**Ports**
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-low.
- `ha_itf`, `intf.rtl` modport: `a`, `b` are inputs of `WIDTH` bits; `s`, `c` are outputs of `WIDTH` bits.
- `carry_cnt`, output, `CNT_W` bits: saturating count of cycles with any carry. Present only with `HALF_ADDER_CNT_EN`.

**Interface `intf`**
- Port `clk`.
- Signals `a`, `b`, `s`, `c`.
- Modport `tb`: drives `a`, `b`; samples `s`, `c`.
- Modport `rtl`: the reverse of `tb`.
- Clocking block `cb` on `posedge clk`, input skew #2, output skew #2.

## Operation
- Per lane i on each rising edge:
  - `s[i] <= a[i] ^ b[i]`
  - `c[i] <= a[i] & b[i]`
- Lanes are fully independent. There is no carry between lanes.
- Truth table per lane (`a`,`b` -> `c`,`s`):
  - 0,0 -> 0,0
  - 0,1 -> 0,1
  - 1,0 -> 0,1
  - 1,1 -> 1,0
- The 2-bit result `{c,s}` always equals `a+b`. No overflow is possible.
- Carry counter (when compiled in):
  - Increments by 1 on each clock edge where the *registered* `c` is non-zero.
  - Saturates at all-ones and holds there.
- X/Z on an input propagates to that lane's outputs only. There is no internal masking.

## Timing
- Latency is 1 cycle. Inputs are sampled at edge N; `s`/`c` are valid after edge N and stable until edge N+1.
- Throughput: one new operand pair per cycle. There is no handshake and no stall.
- Reset:
  - While `rst`=0, `s`, `c` and `carry_cnt` are 0, regardless of the clock.
  - On the `rst` falling edge, outputs clear immediately, without waiting for a clock edge.
  - On release, the first computed result appears after the first rising edge with `rst`=1.
- Inputs that change between edges have no effect until the next edge.
- Reset asserted mid-stream discards the in-flight result. It does not restart or replay anything.

## Configuration
- `HALF_ADDER_CNT_EN` defined: the `carry_cnt` port and its counter register exist.
- `HALF_ADDER_CNT_EN` undefined: no counter logic and no `carry_cnt` port. Sum and carry behaviour is identical in both builds.

## Structure
- Package `half_adder_pkg` holds:
  - `WIDTH` and `CNT_W` defaults as localparams.
  - Typedef `ha_lane_t` (`logic [WIDTH-1:0]`).
  - Typedef `ha_cnt_t` (`logic [CNT_W-1:0]`).
  - Constant `HA_CNT_MAX` (all ones).
- `intf` lives in its own file and imports the package.
- One sub-module, `half_adder_lane`: a single-bit registered XOR/AND with async active-low clear. The top generates `WIDTH` instances of it plus the optional counter.

## Test plan
- **Reset:** hold `rst`=0 with `a`=1, `b`=1 for 3 cycles -> `s`=0, `c`=0, `carry_cnt`=0 throughout.
- **Exhaustive (WIDTH=1):** after reset release, apply 00, 01, 10, 11 on consecutive edges -> one cycle later `{c,s}` reads 00, 01, 01, 10. Check with `cb` sampling (#2 skew).
- **Lane independence (WIDTH=4):**
  - `a`=4'b1100, `b`=4'b1010 -> next cycle `s`=4'b0110, `c`=4'b1000.
- **Async reset mid-stream:** drive `a`=`b`=1, then drop `rst` between edges -> `c` goes to 0 before the next edge; after release, `c`=1 one edge later.
- **Counter (`HALF_ADDER_CNT_EN`):**
  - 5 cycles with `a`=`b`=1, then 3 cycles with `a`=`b`=0 -> `carry_cnt`=5.
  - With `CNT_W`=3 and 10 carry cycles -> `carry_cnt` holds at 7.
- **Build without `HALF_ADDER_CNT_EN`:** same exhaustive vectors -> identical `s`/`c`, and the `carry_cnt` port is absent.
